// File: rtl/decompress_pkg.sv
// Shared geometry, header helpers and FSM state type for the value lane aligner.
package decompress_pkg;

    localparam int WORD_BITS      = 512;
    localparam int LANE_BITS      = 64;
    localparam int LANES_PER_WORD = WORD_BITS / LANE_BITS;
    localparam int LANE_BYTES     = LANE_BITS / 8;
    localparam int HDR_W          = 16;

    typedef logic [$clog2(LANES_PER_WORD)-1:0] lane_idx_t;

    typedef enum logic {
        ST_HDR,
        ST_EMIT
    } state_t;

    // Lanes occupied by a value of len bytes; a zero length still occupies one lane.
    function automatic logic [HDR_W:0] lanes_of(input logic [HDR_W-1:0] len);
        logic [HDR_W:0] sum;
        sum = {1'b0, len} + (HDR_W+1)'(LANE_BYTES - 1);
        if (len == '0) return (HDR_W+1)'(1);
        return sum >> $clog2(LANE_BYTES);
    endfunction

endpackage

// File: rtl/lane_window_shift.sv
// Picks cnt consecutive lanes out of the 2-word window starting at rd_lane; lanes past cnt read zero.
module lane_window_shift
    import decompress_pkg::*;
#(
    parameter int LPW       = LANES_PER_WORD,
    parameter int LANE_SIZE = LANE_BITS
) (
    input  logic [2*LPW-1:0][LANE_SIZE-1:0] win,
    input  lane_idx_t                       rd_lane,
    input  logic [$clog2(LPW):0]            cnt,
    output logic [LPW-1:0][LANE_SIZE-1:0]   lanes
);
    localparam int IW = $clog2(LPW) + 1;

    for (genvar k = 0; k < LPW; k++) begin : g_lane
        logic [IW-1:0] src;
        assign src      = IW'(rd_lane) + IW'(k);
        assign lanes[k] = (IW'(k) < cnt) ? win[src] : '0;
    end

endmodule

// File: rtl/value_lane_aligner.sv
// Re-aligns a lane-packed value stream so each value starts at lane 0 of its own output word.
// Optional counters stat_values / stat_pad_words are built when VALUE_LANE_ALIGNER_STATS_EN is defined.
module value_lane_aligner
    import decompress_pkg::*;
#(
    parameter int WORD_SIZE           = 512,
    parameter int LANE_SIZE           = 64,
    parameter int VALUE_SIZE_BYTES_NO = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
`ifdef VALUE_LANE_ALIGNER_STATS_EN
    output logic [31:0]          stat_values,
    output logic [31:0]          stat_pad_words,
`endif
    output logic                 err_trunc
);
    localparam int LPW   = WORD_SIZE / LANE_SIZE;
    localparam int HW    = 8 * VALUE_SIZE_BYTES_NO;
    localparam int CNT_W = $clog2(LPW) + 1;
    localparam int REM_W = HW + 1;

    typedef logic [LPW-1:0][LANE_SIZE-1:0] word_t;

    state_t           state, state_nx;
    word_t            cur, nxt, shifted;
    logic             cur_v, nxt_v, cur_last, nxt_last, alive;
    lane_idx_t        rd_lane;
    logic [REM_W-1:0] rem_lanes, rem_eff;
    logic [HW-1:0]    hdr_len;
    logic [CNT_W-1:0] avail, n_take, cnt, sum;
    logic             pad, act, trunc, fire, vend, retire, accept;

    assign hdr_len = cur[rd_lane][HW-1:0];

    // A header is consumed in the same cycle it is emitted, so HDR fires directly.
    always_comb begin
        state_nx = state;
        pad      = 1'b0;
        act      = 1'b0;
        rem_eff  = (state == ST_HDR) ? lanes_of(hdr_len) : rem_lanes;
        avail    = CNT_W'(LPW) - CNT_W'(rd_lane);
        n_take   = (rem_eff >= REM_W'(LPW)) ? CNT_W'(LPW) : rem_eff[CNT_W-1:0];
        if (cur_v) begin
            pad = (state == ST_HDR) && (hdr_len == '0);
            act = !pad;
        end
        // Values never span packets: a short in_last word ends the value early.
        trunc  = cur_last && (rem_eff > REM_W'(avail));
        cnt    = trunc ? avail : n_take;
        fire   = act && (!out_valid || out_ready) && (cur_last || n_take <= avail || nxt_v);
        vend   = trunc || (rem_eff <= REM_W'(LPW));
        sum    = CNT_W'(rd_lane) + cnt;
        retire = pad || (fire && (trunc || sum[CNT_W-1]));
        if (act) state_nx = (fire && vend) ? ST_HDR : ST_EMIT;
    end

    assign in_ready = alive && (!nxt_v || retire);
    assign accept   = in_valid && in_ready;

    lane_window_shift #(.LPW(LPW), .LANE_SIZE(LANE_SIZE)) u_shift (
        .win     ({nxt, cur}),
        .rd_lane (rd_lane),
        .cnt     (cnt),
        .lanes   (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_HDR;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            nxt       <= '0;
            cur_v     <= 1'b0;
            nxt_v     <= 1'b0;
            cur_last  <= 1'b0;
            nxt_last  <= 1'b0;
            alive     <= 1'b0;
            rd_lane   <= '0;
            rem_lanes <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (retire && nxt_v) begin
                cur      <= nxt;
                cur_last <= nxt_last;
                nxt_v    <= accept;
                if (accept) begin
                    nxt      <= in_data;
                    nxt_last <= in_last;
                end
            end else if (retire || (accept && !cur_v)) begin
                cur_v <= accept;
                if (accept) begin
                    cur      <= in_data;
                    cur_last <= in_last;
                end
            end else if (accept) begin
                nxt      <= in_data;
                nxt_last <= in_last;
                nxt_v    <= 1'b1;
            end

            if (pad)       rd_lane <= '0;
            else if (fire) rd_lane <= lane_idx_t'(sum[CNT_W-2:0]);
            if (act)       rem_lanes <= fire ? rem_eff - REM_W'(cnt) : rem_eff;

            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= shifted;
                out_last  <= vend;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            err_trunc <= err_trunc | (fire & trunc);
        end
    end

`ifdef VALUE_LANE_ALIGNER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_values    <= '0;
            stat_pad_words <= '0;
        end else begin
            if (out_valid && out_ready && out_last) stat_values <= stat_values + 32'd1;
            if (pad) stat_pad_words <= stat_pad_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_value_lane_aligner.sv
// Table-driven bench for value_lane_aligner: a lane packer builds input words and pushes expected output words to a scoreboard.
module tb_value_lane_aligner;
    localparam int WS  = 512;
    localparam int LPW = 8;

    typedef logic [WS-1:0] word_t;
    typedef struct { word_t d; logic l; } exp_t;
    typedef struct { int unsigned len; bit pad; bit eop; int exp_words; } vec_t;

    logic  clk = 1'b0, rst = 1'b1;
    word_t in_data = '0;
    logic  in_valid = 1'b0, in_last = 1'b0, in_ready;
    word_t out_data;
    logic  out_valid, out_last, err_trunc;
    logic  out_ready = 1'b0;

    int checks = 0, errors = 0;
    int out_words = 0, out_values = 0, in_stalls = 0, rdy_mode = 0;
    exp_t sb[$];
    logic [63:0] pk[$];
    vec_t tbl[10];
    bit    stalled = 0;
    word_t held_d;
    logic  held_l;

    always #5 clk = ~clk;

    value_lane_aligner dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err_trunc(err_trunc)
    );

    task automatic chk(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Output side: scoreboard pop plus stall-stability check, sampled mid-cycle.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) stalled = 0;
            else begin
                if (stalled) begin
                    chk1("stall_valid", out_valid, 1'b1);
                    chk("stall_data", out_data, held_d);
                    chk1("stall_last", out_last, held_l);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_out got %0h exp none", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk1("out_last", out_last, e.l);
                    end
                    out_words++;
                    if (out_last) out_values++;
                end
                stalled = out_valid && !out_ready;
                held_d  = out_data;
                held_l  = out_last;
            end
        end
    end

    initial begin : rdy
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic push_word(input word_t d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        in_data = d; in_last = l; in_valid = 1'b1;
        forever begin
            #4;
            if (in_ready) break;
            in_stalls++;
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout got 0 exp 1");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Padding marker at the current lane, then filler to the end of the word.
    task automatic add_pad();
        logic [63:0] r;
        r = rnd64();
        r[15:0] = '0;
        pk.push_back(r);
        while (pk.size() % LPW != 0) pk.push_back(rnd64());
    endtask

    task automatic add_value(input int unsigned len);
        int n, k;
        logic [63:0] r;
        exp_t e;
        n = (len + 7) / 8;
        if (n == 0) n = 1;
        k = 0;
        e.d = '0;
        for (int i = 0; i < n; i++) begin
            r = rnd64();
            if (i == 0) r[15:0] = len[15:0];
            pk.push_back(r);
            e.d[k*64 +: 64] = r;
            k++;
            if (k == LPW || i == n - 1) begin
                e.l = (i == n - 1);
                sb.push_back(e);
                e.d = '0;
                k = 0;
            end
        end
    endtask

    task automatic send_pkt();
        word_t w;
        int nw;
        if (pk.size() % LPW != 0) add_pad();
        nw = pk.size() / LPW;
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < LPW; j++) w[j*64 +: 64] = pk[i*LPW + j];
            push_word(w, i == nw - 1);
        end
        pk.delete();
    endtask

    task automatic run_table(output int exp_total);
        exp_total = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].pad) add_pad();
            add_value(tbl[i].len);
            exp_total += tbl[i].exp_words;
            if (tbl[i].eop) send_pkt();
        end
    endtask

    task automatic wait_drain(input string nm);
        int g;
        g = 0;
        while ((sb.size() != 0 || out_valid) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending exp 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin : main
        int exp_total, base, g;
        word_t w;
        logic [63:0] ln[8];
        exp_t e;

        // {len bytes, pad marker before, end of packet after, output words}
        tbl[0] = '{20,  1'b0, 1'b0, 1};
        tbl[1] = '{40,  1'b0, 1'b1, 1};
        tbl[2] = '{40,  1'b0, 1'b0, 1};
        tbl[3] = '{100, 1'b0, 1'b1, 2};
        tbl[4] = '{48,  1'b0, 1'b0, 1};
        tbl[5] = '{8,   1'b1, 1'b0, 1};
        tbl[6] = '{1,   1'b0, 1'b0, 1};
        tbl[7] = '{64,  1'b0, 1'b0, 1};
        tbl[8] = '{65,  1'b0, 1'b1, 2};
        tbl[9] = '{200, 1'b1, 1'b1, 4};

        repeat (3) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk1("rst_err_trunc", err_trunc, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk1("in_ready_up", in_ready, 1'b1);

        // Free-flowing output
        out_words = 0; out_values = 0;
        run_table(exp_total);
        wait_drain("drain_flow");
        chk("flow_words", word_t'(out_words), word_t'(exp_total));
        chk("flow_values", word_t'(out_values), word_t'(10));
        chk1("flow_no_trunc", err_trunc, 1'b0);

        // Backpressure: out_ready toggling every cycle
        out_words = 0; out_values = 0; in_stalls = 0;
        rdy_mode = 1;
        run_table(exp_total);
        wait_drain("drain_bp");
        rdy_mode = 0;
        chk("bp_words", word_t'(out_words), word_t'(exp_total));
        chk("bp_values", word_t'(out_values), word_t'(10));
        chk1("bp_in_ready_dropped", in_stalls > 0, 1'b1);

        // Truncation: L=80 at lane 4 of an in_last word
        for (int j = 0; j < LPW; j++) ln[j] = rnd64();
        ln[0][15:0] = 16'd32;
        ln[4][15:0] = 16'd80;
        e.d = '0;
        for (int j = 0; j < 4; j++) e.d[j*64 +: 64] = ln[j];
        e.l = 1'b1;
        sb.push_back(e);
        e.d = '0;
        for (int j = 0; j < 4; j++) e.d[j*64 +: 64] = ln[j+4];
        sb.push_back(e);
        for (int j = 0; j < LPW; j++) w[j*64 +: 64] = ln[j];
        push_word(w, 1'b1);
        add_value(16);
        send_pkt();
        wait_drain("drain_trunc");
        chk1("trunc_err_set", err_trunc, 1'b1);
        repeat (3) @(negedge clk);
        chk1("trunc_err_held", err_trunc, 1'b1);

        // Reset midway through a 13-lane value
        for (int j = 0; j < LPW; j++) ln[j] = rnd64();
        ln[0][15:0] = 16'd100;
        for (int j = 0; j < LPW; j++) w[j*64 +: 64] = ln[j];
        e.d = w; e.l = 1'b0;
        sb.push_back(e);
        base = out_words;
        push_word(w, 1'b0);
        g = 0;
        while (out_words == base && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("mid_first_word", word_t'(out_words - base), word_t'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_out_last", out_last, 1'b0);
        chk("mid_rst_out_data", out_data, '0);
        chk1("mid_rst_err_trunc", err_trunc, 1'b0);
        rst = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        add_value(40);
        add_value(20);
        send_pkt();
        wait_drain("drain_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
